hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
// - Pipeline controller for the 5-stage core: sequences the execute stage and its neighbours.
// - Generates the execute-stage operand forwarding selects, load-use stalls, branch flushes,
//   and a freeze of the whole pipe while a multi-cycle data-memory access is pending.
// - Sits beside the datapath. Consumes register indices and control bits from the D/E/M/W stages.
//   Drives the stall and flush enables of the F/D, D/E and E/M pipeline registers.
// PARAMETERS
// - MEM_TIMEOUT  default 16  max MEM_WAIT cycles before abort; legal range 1..255
// PORTS
// - clk         in   1   clock, rising edge
// - rst         in   1   asynchronous reset, active-low
// - Rs1_D       in   5   rs1 index of instruction in decode
// - Rs2_D       in   5   rs2 index of instruction in decode
// - Rs1_E       in   5   rs1 index of instruction in execute
// - Rs2_E       in   5   rs2 index of instruction in execute
// - RD_E        in   5   destination index in execute
// - RD_M        in   5   destination index in memory stage
// - RD_W        in   5   destination index in writeback
// - ResultSrcE  in   1   1 = instruction in execute is a load
// - RegWriteM   in   1   memory-stage instruction writes the register file
// - RegWriteW   in   1   writeback instruction writes the register file
// - PCSrcE      in   1   branch taken, resolved in execute
// - MemReqM     in   1   memory stage issues a load or store this cycle
// - DmemReady   in   1   data memory completes the access this cycle
// - ForwardA_E  out  2   SrcA select: 00 = RD1_E, 01 = ResultW, 10 = ALU_ResultM
// - ForwardB_E  out  2   SrcB select, same encoding as ForwardA_E
// - StallF      out  1   hold the PC
// - StallD      out  1   hold the F/D register
// - StallE      out  1   hold the D/E register
// - StallM      out  1   hold the E/M register and the M/W register
// - FlushD      out  1   clear the F/D register to a bubble
// - FlushE      out  1   clear the D/E register to a bubble
// - MemErr      out  1   one-cycle pulse when a memory access times out
// BEHAVIOUR
// - Forwarding (combinational), per operand X in {1,2}:
//   - 10 if RegWriteM && RD_M!=0 && RD_M==RsX_E.
//   - else 01 if RegWriteW && RD_W!=0 && RD_W==RsX_E.
//   - else 00.
//   - The memory stage has priority over writeback. Index x0 never forwards.
// - lw_stall = ResultSrcE && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D).
// - FSM state register, reset to RUN. Wait counter wcnt is 8 bits, reset to 0.
//   - RUN:
//     - If MemReqM && !DmemReady: mem_stall=1, next state MEM_WAIT, wcnt<=1.
//     - Otherwise mem_stall=0.
//   - MEM_WAIT: mem_stall=1 and wcnt increments each cycle.
//     - If DmemReady: mem_stall=0 this cycle, next state RUN, wcnt<=0.
//     - Else if wcnt==MEM_TIMEOUT: MemErr=1 and mem_stall=0 this cycle, next state RUN, wcnt<=0.
// - Output priority, highest first:
//   1. mem_stall=1: StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0.
//      PCSrcE and lw_stall are deferred; E is frozen, so they re-evaluate on release.
//   2. PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0. lw_stall is ignored because D is killed.
//   3. lw_stall=1: StallF=StallD=1, FlushE=1, StallE=StallM=0.
//   4. Otherwise all stall and flush outputs are 0.
// - Latency: forwarding, stall and flush are combinational and valid in the same cycle.
//   The only registered elements are the FSM state and wcnt (plus the counters below).
// - Reset: while rst=0, state=RUN, wcnt=0. All outputs are forced to 0, Forward* included.
// - Reset asserted during MEM_WAIT aborts the wait immediately. No MemErr pulse.
// - DmemReady while in RUN with MemReqM=1 is a single-cycle access: no stall and no FSM change.
// CONFIGURATION
// - Macro HAZARD_PERF_CNT_EN. When defined, adds these output ports:
//   - stall_cnt  out 32: counts cycles with StallF=1.
//   - flush_cnt  out 32: counts cycles with FlushE=1.
//   - memerr_cnt out 16: counts MemErr pulses.
//   - All three reset to 0 and saturate at all-ones. No wrap.
// - When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.
// TESTING
// - Forwarding priority: RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5, Rs2_E=0
//   -> ForwardA_E=10, ForwardB_E=00.
// - Load-use: ResultSrcE=1, RD_E=7, Rs2_D=7, PCSrcE=0
//   -> StallF=StallD=FlushE=1, FlushD=0. Repeat with RD_E=0 -> all 0.
// - Branch beats load-use: PCSrcE=1, lw_stall conditions true
//   -> FlushD=FlushE=1, StallF=StallD=0.
// - Memory wait: MemReqM=1, DmemReady low for 3 cycles then high
//   -> all four stalls =1 for 3 cycles, 0 on the DmemReady cycle, state returns to RUN.
// - Timeout with MEM_TIMEOUT=4: DmemReady held low
//   -> MemErr pulses once, 4 cycles after entering MEM_WAIT. Stalls drop that cycle.
// - Reset mid-wait: rst=0 during MEM_WAIT
//   -> all outputs 0 immediately, no MemErr. With the macro defined, counters read 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard and pipeline control for the 5-stage core: forwarding, load-use stall,
// branch flush and memory-wait freeze. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] RD_E,
  input  logic [4:0] RD_M,
  input  logic [4:0] RD_W,
  input  logic       ResultSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       DmemReady,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [15:0] memerr_cnt
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  logic [1:0] state, next_state;
  logic [7:0] wcnt, next_wcnt;
  logic       mem_stall, mem_err, lw_stall;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && RD_M != 5'd0 && RD_M == Rs1_E)
      fwd_a = 2'b10;
    else if (RegWriteW && RD_W != 5'd0 && RD_W == Rs1_E)
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (RegWriteM && RD_M != 5'd0 && RD_M == Rs2_E)
      fwd_b = 2'b10;
    else if (RegWriteW && RD_W != 5'd0 && RD_W == Rs2_E)
      fwd_b = 2'b01;
  end

  assign lw_stall = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // Release and timeout both drop the stall in the same cycle they are seen
  always_comb begin
    next_state = state;
    next_wcnt  = wcnt;
    mem_stall  = 1'b0;
    mem_err    = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !DmemReady) begin
          mem_stall  = 1'b1;
          next_state = MEM_WAIT;
          next_wcnt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (DmemReady) begin
          next_state = RUN;
          next_wcnt  = 8'd0;
        end else if (wcnt == TIMEOUT) begin
          mem_err    = 1'b1;
          next_state = RUN;
          next_wcnt  = 8'd0;
        end else begin
          mem_stall = 1'b1;
          next_wcnt = wcnt + 8'd1;
        end
      end
      default: begin
        next_state = RUN;
        next_wcnt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= next_state;
      wcnt  <= next_wcnt;
    end
  end

  // Outputs are held at zero for as long as reset is asserted
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    MemErr     = 1'b0;
    if (rst) begin
      ForwardA_E = fwd_a;
      ForwardB_E = fwd_b;
      MemErr     = mem_err;
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      memerr_cnt <= 16'd0;
    end else begin
      if (StallF && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (FlushE && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
      if (MemErr && memerr_cnt != 16'hFFFF)
        memerr_cnt <= memerr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios followed by
// randomized traffic checked against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int TIMEOUT = 4;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, DmemReady;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [15:0] memerr_cnt;
`endif

  int test_count = 0;
  int fail_count = 0;

  // Model state: cycles spent on the current outstanding memory access (0 = idle)
  int          waited = 0;
  longint      m_stall_cnt = 0;
  longint      m_flush_cnt = 0;
  longint      m_memerr_cnt = 0;

  hazard_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .DmemReady(DmemReady),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memerr_cnt(memerr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [1:0] expFwd(input logic [4:0] rs);
    if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearInputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
    RD_E = 0; RD_M = 0; RD_W = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; MemReqM = 0; DmemReady = 0;
  endtask

  // Called at a falling edge with inputs set; checks, then advances one cycle
  task automatic applyStimulus();
    logic       mstall, merr, lw;
    logic [3:0] e_stall;
    logic [1:0] e_flush, e_fa, e_fb;
    int         next_waited;
    #1;
    mstall = 1'b0;
    merr   = 1'b0;
    next_waited = 0;
    if (waited == 0) begin
      mstall = MemReqM && !DmemReady;
      next_waited = mstall ? 1 : 0;
    end else if (!DmemReady) begin
      if (waited == TIMEOUT) merr = 1'b1;
      else begin
        mstall = 1'b1;
        next_waited = waited + 1;
      end
    end
    lw = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    e_fa = expFwd(Rs1_E);
    e_fb = expFwd(Rs2_E);
    if (!rst) begin
      e_stall = 4'b0000; e_flush = 2'b00; e_fa = 2'b00; e_fb = 2'b00;
      merr = 1'b0; next_waited = 0;
    end else if (mstall) begin
      e_stall = 4'b1111; e_flush = 2'b00;
    end else if (PCSrcE) begin
      e_stall = 4'b0000; e_flush = 2'b11;
    end else if (lw) begin
      e_stall = 4'b1100; e_flush = 2'b01;
    end else begin
      e_stall = 4'b0000; e_flush = 2'b00;
    end
    checkOutput("fwdA", 32'(ForwardA_E), 32'(e_fa));
    checkOutput("fwdB", 32'(ForwardB_E), 32'(e_fb));
    checkOutput("stalls", 32'({StallF, StallD, StallE, StallM}), 32'(e_stall));
    checkOutput("flushes", 32'({FlushD, FlushE}), 32'(e_flush));
    checkOutput("memerr", 32'(MemErr), 32'(merr));
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    checkOutput("flush_cnt", flush_cnt, 32'(m_flush_cnt));
    checkOutput("memerr_cnt", 32'(memerr_cnt), 32'(m_memerr_cnt));
`endif
    @(posedge clk);
    waited = next_waited;
    if (!rst) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_memerr_cnt = 0;
    end else begin
      if (e_stall[3] && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (e_flush[0] && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
      if (merr && m_memerr_cnt < 64'hFFFF) m_memerr_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    RegWriteM = 1; RD_M = 5'd3; Rs1_E = 5'd3; PCSrcE = 1; MemReqM = 1;
    #1;
    checkOutput("reset_outputs", 32'({ForwardA_E, StallF, FlushD, FlushE, MemErr}), 32'd0);
    applyStimulus();
    rst = 1'b1;
    clearInputs();
    applyStimulus();

    // Forwarding priority: memory stage beats writeback, x0 never forwards
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 0;
    #1;
    checkOutput("fwd_prio_A", 32'(ForwardA_E), 32'd2);
    checkOutput("fwd_prio_B", 32'(ForwardB_E), 32'd0);
    applyStimulus();
    clearInputs();

    // Load-use stall, then the same with destination x0
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
    #1;
    checkOutput("loaduse", 32'({StallF, StallD, FlushE, FlushD}), 32'b1110);
    applyStimulus();
    RD_E = 0;
    #1;
    checkOutput("loaduse_x0", 32'({StallF, StallD, FlushE, FlushD}), 32'b0000);
    applyStimulus();

    // Branch takes priority over load-use
    RD_E = 7; PCSrcE = 1;
    #1;
    checkOutput("branch_vs_lw", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);
    applyStimulus();
    clearInputs();

    // Memory wait: three stalled cycles then release
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("memwait_stall", 32'({StallF, StallD, StallE, StallM}), 32'hF);
      applyStimulus();
    end
    DmemReady = 1;
    #1;
    checkOutput("memwait_release", 32'({StallF, StallD, StallE, StallM}), 32'h0);
    applyStimulus();
    clearInputs();
    applyStimulus();

    // Timeout: MemErr on the fifth cycle of the access, stalls drop with it
    MemReqM = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("timeout_err", 32'(MemErr), (i == 4) ? 32'd1 : 32'd0);
      checkOutput("timeout_stall", 32'(StallF), (i == 4) ? 32'd0 : 32'd1);
      applyStimulus();
    end
    clearInputs();
    applyStimulus();

    // Reset asserted mid-wait aborts immediately
    MemReqM = 1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    PCSrcE = 1;
    #1;
    checkOutput("rst_midwait", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr}), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("rst_counters", stall_cnt | flush_cnt | 32'(memerr_cnt), 32'd0);
`endif
    applyStimulus();
    rst = 1'b1;
    clearInputs();
    applyStimulus();

    // Randomized traffic with small register indices to provoke matches
    for (int n = 0; n < 600; n++) begin
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
      RD_W  = 5'($urandom_range(0, 3));
      ResultSrcE = ($urandom_range(0, 2) == 0);
      RegWriteM  = $urandom_range(0, 1) == 1;
      RegWriteW  = $urandom_range(0, 1) == 1;
      PCSrcE     = ($urandom_range(0, 5) == 0);
      MemReqM    = $urandom_range(0, 1) == 1;
      DmemReady  = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 59) != 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
